// File: rtl/common_gnss_types_pkg.sv
// ============================================================================
// Module : common_gnss_types_pkg
// Brief  : Shared GNSS types and constants; L1 C/A acquisition-to-tracking
//          handoff record and fine-search index limits.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package common_gnss_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  sv_t;
    typedef logic [12:0] code_idx_t;
    typedef logic [7:0]  dop_idx_t;

    typedef struct packed {
        sv_t   sv;
        word_t carr_fcw;
        word_t code_phase;
        word_t acc;
    } l1ca_trk_init_t;

    // 1023 chips in 1/8-chip steps, last legal index
    localparam int L1CA_CODE_IDX_MAX    = 8183;
    localparam int L1CA_FINE_DOP_CENTER = 128;
    localparam int L1CA_CONFIRM_WIN     = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CHECK   = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_PUSH    = 2'd3
    } l1ca_handoff_state_t;

    // True when two indices lie within the confirmation window of each other
    function automatic logic l1ca_near(input logic [12:0] a, input logic [12:0] b);
        logic [12:0] diff;
        diff = (a >= b) ? (a - b) : (b - a);
        return (diff <= 13'(L1CA_CONFIRM_WIN));
    endfunction

endpackage

`default_nettype wire

// File: rtl/l1ca_result_fifo.sv
// ============================================================================
// Module : l1ca_result_fifo
// Brief  : Show-ahead FIFO of tracking-init records; push accepted when full
//          only if a pop happens in the same cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module l1ca_result_fifo
    import common_gnss_types_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           nrst,
    input  logic           i_push,
    input  l1ca_trk_init_t i_push_data,
    input  logic           i_pop,
    output l1ca_trk_init_t o_head,
    output logic           o_full,
    output logic           o_empty
);

    localparam int AW = $clog2(DEPTH);

    l1ca_trk_init_t r_mem [DEPTH];
    logic [AW:0]    r_wr_ptr;
    logic [AW:0]    r_rd_ptr;
    logic           w_pop_ok;
    logic           w_push_ok;

    // Extra MSB on each pointer distinguishes full from empty
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end

    assign o_head = r_mem[r_rd_ptr[AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/l1ca_acq_handoff.sv
// ============================================================================
// Module : l1ca_acq_handoff
// Brief  : Qualifies L1 C/A fine-search results and converts them into
//          tracking-loop initial values queued for the channel allocator.
//          Optional macro L1CA_HANDOFF_CONFIRM_EN requires two consistent
//          sightings before a result is accepted.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module l1ca_acq_handoff
    import common_gnss_types_pkg::*;
#(
    parameter int          DEPTH        = 4,
    parameter logic [31:0] IF_FCW       = 32'h0,
    parameter logic [31:0] FCW_PER_BIN  = 32'd8947,
    parameter int          DOP_CENTER   = L1CA_FINE_DOP_CENTER,
    parameter int          CODE_IDX_MAX = L1CA_CODE_IDX_MAX
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        fs_busy,
    input  logic [31:0] fs_acc,
    input  logic [12:0] fs_code_index,
    input  logic [7:0]  fs_dop_index,
    input  logic [4:0]  fs_sv,
    input  logic [31:0] threshold,
    output logic        trk_valid,
    input  logic        trk_ready,
    output logic [4:0]  trk_sv,
    output logic [31:0] trk_carr_fcw,
    output logic [31:0] trk_code_phase,
    output logic [31:0] trk_acc,
    output logic        overflow,
    output logic [7:0]  rejects
);

    l1ca_handoff_state_t r_state;
    l1ca_handoff_state_t w_next_state;

    logic           r_busy_d;
    logic           w_busy_fall;
    word_t          r_hold_acc;
    code_idx_t      r_hold_code;
    dop_idx_t       r_hold_dop;
    sv_t            r_hold_sv;
    word_t          r_fcw;
    word_t          r_code_phase;
    logic           r_overflow;
    logic [7:0]     r_rejects;

    logic           w_pass;
    logic           w_accept;
    logic           w_push;
    logic [8:0]     w_dop_delta;
    word_t          w_dop_ext;
    word_t          w_fcw;
    l1ca_trk_init_t w_push_data;
    l1ca_trk_init_t w_head;
    logic           w_fifo_full;
    logic           w_fifo_empty;
    logic           w_fifo_pop;

    assign w_busy_fall = r_busy_d && !fs_busy;
    assign w_pass      = (r_hold_acc >= threshold) &&
                         (r_hold_code <= 13'(CODE_IDX_MAX));

    // Low 32 bits of the sign-extended product give the modulo-2^32 result
    assign w_dop_delta = {1'b0, r_hold_dop} - 9'(DOP_CENTER);
    assign w_dop_ext   = {{23{w_dop_delta[8]}}, w_dop_delta};
    assign w_fcw       = IF_FCW + (w_dop_ext * FCW_PER_BIN);

`ifdef L1CA_HANDOFF_CONFIRM_EN
    logic      r_cand_valid;
    sv_t       r_cand_sv;
    code_idx_t r_cand_code;
    dop_idx_t  r_cand_dop;
    logic      w_match;

    assign w_match  = r_cand_valid && (r_cand_sv == r_hold_sv) &&
                      l1ca_near(r_cand_code, r_hold_code) &&
                      l1ca_near({5'b0, r_cand_dop}, {5'b0, r_hold_dop});
    assign w_accept = w_pass && w_match;

    // Every qualifying result becomes the reference for the next one
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cand_valid <= 1'b0;
            r_cand_sv    <= '0;
            r_cand_code  <= '0;
            r_cand_dop   <= '0;
        end else if (r_state == ST_CHECK && w_pass) begin
            r_cand_valid <= 1'b1;
            r_cand_sv    <= r_hold_sv;
            r_cand_code  <= r_hold_code;
            r_cand_dop   <= r_hold_dop;
        end
    end
`else
    assign w_accept = w_pass;
`endif

    always_comb begin
        w_next_state = r_state;
        w_push       = 1'b0;
        case (r_state)
            ST_IDLE:    if (w_busy_fall) w_next_state = ST_CHECK;
            ST_CHECK:   w_next_state = w_accept ? ST_COMPUTE : ST_IDLE;
            ST_COMPUTE: w_next_state = ST_PUSH;
            ST_PUSH: begin
                w_push       = 1'b1;
                w_next_state = ST_IDLE;
            end
            default:    w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state      <= ST_IDLE;
            r_busy_d     <= 1'b0;
            r_hold_acc   <= '0;
            r_hold_code  <= '0;
            r_hold_dop   <= '0;
            r_hold_sv    <= '0;
            r_fcw        <= '0;
            r_code_phase <= '0;
            r_overflow   <= 1'b0;
            r_rejects    <= '0;
        end else begin
            r_state  <= w_next_state;
            r_busy_d <= fs_busy;
            if (r_state == ST_IDLE && w_busy_fall) begin
                r_hold_acc  <= fs_acc;
                r_hold_code <= fs_code_index;
                r_hold_dop  <= fs_dop_index;
                r_hold_sv   <= fs_sv;
            end
            if (r_state == ST_CHECK && !w_pass && r_rejects != 8'hFF) begin
                r_rejects <= r_rejects + 8'd1;
            end
            if (r_state == ST_COMPUTE) begin
                r_fcw        <= w_fcw;
                r_code_phase <= {r_hold_code, 19'b0};
            end
            if (w_push && w_fifo_full && !w_fifo_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign w_push_data = '{sv: r_hold_sv, carr_fcw: r_fcw,
                           code_phase: r_code_phase, acc: r_hold_acc};
    assign w_fifo_pop  = !w_fifo_empty && trk_ready;

    l1ca_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .nrst        (nrst),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_fifo_pop),
        .o_head      (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    // Head fields are gated so every output reads zero whenever nothing is queued
    assign trk_valid      = !w_fifo_empty;
    assign trk_sv         = trk_valid ? w_head.sv         : '0;
    assign trk_carr_fcw   = trk_valid ? w_head.carr_fcw   : '0;
    assign trk_code_phase = trk_valid ? w_head.code_phase : '0;
    assign trk_acc        = trk_valid ? w_head.acc        : '0;
    assign overflow       = r_overflow;
    assign rejects        = r_rejects;

endmodule

`default_nettype wire
